// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator output mux and its readout stage.
// Select codes, readout FSM states and the default frame header.
package acc_pkg;

    localparam int unsigned SEL_WIDTH = 3;

    localparam logic [SEL_WIDTH-1:0] SEL_LSB   = 3'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_MSB   = 3'd1;
    localparam logic [SEL_WIDTH-1:0] SEL_CNT   = 3'd2;
    localparam logic [SEL_WIDTH-1:0] SEL_CARRY = 3'd3;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StHdr,
        StPay,
        StCsum
    } acc_state_e;

    // Snapshot field index to mux select; codes 4-7 are never produced.
    function automatic logic [SEL_WIDTH-1:0] field_sel(input logic [1:0] idx);
        logic [SEL_WIDTH-1:0] sel;
        case (idx)
            2'd0:    sel = SEL_LSB;
            2'd1:    sel = SEL_MSB;
            2'd2:    sel = SEL_CNT;
            default: sel = SEL_CARRY;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/acc_snapshot.sv
// Steps the accumulator output select through its four fields, waits for the mux
// to settle on each, and captures the fields into a 4-byte buffer.
module acc_snapshot
    import acc_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic [7:0]           acc_data,
    output logic [SEL_WIDTH-1:0] output_sel,
    output logic                 done,
    output logic [31:0]          snap_bytes
);

    localparam logic [2:0] SettleInit = 3'(SETTLE_CYCLES);

    logic            active_q, active_d;
    logic [1:0]      idx_q, idx_d;
    logic [2:0]      settle_q, settle_d;
    logic [3:0][7:0] buf_q, buf_d;
    logic [7:0]      field;

    assign output_sel = field_sel(idx_q);
    assign snap_bytes = buf_q;

    always_comb begin
        // Only bit 0 of the carry field is meaningful on the mux.
        field    = (output_sel == SEL_CARRY) ? {7'b0, acc_data[0]} : acc_data;
        active_d = active_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        buf_d    = buf_q;
        done     = 1'b0;
        if (go) begin
            active_d = 1'b1;
            idx_d    = 2'd0;
            settle_d = SettleInit;
        end else if (active_q) begin
            if (settle_q != 3'd0) begin
                settle_d = settle_q - 3'd1;
            end else begin
                buf_d[idx_q] = field;
                settle_d     = SettleInit;
                if (idx_q == 2'd3) begin
                    active_d = 1'b0;
                    idx_d    = 2'd0;
                    done     = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            idx_q    <= 2'd0;
            settle_q <= 3'd0;
            buf_q    <= '0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            buf_q    <= buf_d;
        end
    end

endmodule

// File: rtl/acc_readout.sv
// Accumulator readout: snapshots the result fields under acc_hold and ships them
// as a framed byte stream. Define ACC_READOUT_CHKSUM_EN to append an XOR byte.
module acc_readout
    import acc_pkg::*;
#(
    parameter logic [7:0]  HEADER        = HEADER_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           acc_data,
    output logic [SEL_WIDTH-1:0] output_sel,
    output logic                 acc_hold,
    output logic                 busy,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    acc_state_e  state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        snap_go;
    logic        snap_done;
    logic [31:0] snap_bytes;
    logic [7:0]  pay_byte;

    acc_snapshot #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_snapshot (
        .clock      (clock),
        .reset      (reset),
        .go         (snap_go),
        .acc_data   (acc_data),
        .output_sel (output_sel),
        .done       (snap_done),
        .snap_bytes (snap_bytes)
    );

    assign pay_byte = snap_bytes[{byte_idx_q, 3'b000} +: 8];

`ifdef ACC_READOUT_CHKSUM_EN
    logic [7:0] csum;
    assign csum = snap_bytes[7:0] ^ snap_bytes[15:8] ^ snap_bytes[23:16] ^ snap_bytes[31:24];
`endif

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        snap_go    = 1'b0;
        busy       = 1'b1;
        acc_hold   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    snap_go = 1'b1;
                    state_d = StSnap;
                end
            end
            StSnap: begin
                acc_hold = 1'b1;
                if (snap_done) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                out_valid = 1'b1;
                out_data  = HEADER;
                if (out_ready) begin
                    state_d    = StPay;
                    byte_idx_d = 2'd0;
                end
            end
            StPay: begin
                out_valid = 1'b1;
                out_data  = pay_byte;
                if (out_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = 2'd0;
`ifdef ACC_READOUT_CHKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
`ifdef ACC_READOUT_CHKSUM_EN
            StCsum: begin
                out_valid = 1'b1;
                out_data  = csum;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            byte_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: tb/tb_acc_readout.sv
// Self-checking bench for acc_readout: table-driven frames with a byte scoreboard,
// plus hand-written reset-abort and long-settle sequences.
module tb_acc_readout;
    import acc_pkg::*;

`ifdef ACC_READOUT_CHKSUM_EN
    localparam int FrameLen = 6;
`else
    localparam int FrameLen = 5;
`endif

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic [7:0] cnt;
        logic [7:0] carry_src;
        logic [7:0] carry_exp;
        logic [7:0] csum;
        int         ready_mode;
        int         inject_at;
    } vec_t;

    logic       clock, reset, start, start3, out_ready;
    logic [7:0] acc_data, acc_data3, out_data, out_data3;
    logic [2:0] output_sel, output_sel3;
    logic       acc_hold, busy, out_valid, acc_hold3, busy3, out_valid3;
    logic [7:0] m_lsb, m_msb, m_cnt, m_carry;

    int         total, bad;
    logic [7:0] exp_q[$];
    int         pops, ready_mode, ready_phase, inject_at, hold_cycles;
    int         sel_cycles[8];
    logic       sel_order_bad, pend_stall, expect_idle;
    logic [2:0] last_sel;
    logic [7:0] pend_data;
    vec_t       vecs[5];

    // Accumulator mux model
    assign acc_data  = (output_sel == SEL_LSB) ? m_lsb : (output_sel == SEL_MSB) ? m_msb :
                       (output_sel == SEL_CNT) ? m_cnt : (output_sel == SEL_CARRY) ? m_carry : 8'hEE;
    assign acc_data3 = (output_sel3 == SEL_LSB) ? m_lsb : (output_sel3 == SEL_MSB) ? m_msb :
                       (output_sel3 == SEL_CNT) ? m_cnt : (output_sel3 == SEL_CARRY) ? m_carry : 8'hEE;

    acc_readout dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .acc_data   (acc_data),
        .output_sel (output_sel),
        .acc_hold   (acc_hold),
        .busy       (busy),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    acc_readout #(.SETTLE_CYCLES(3)) dut3 (
        .clock      (clock),
        .reset      (reset),
        .start      (start3),
        .acc_data   (acc_data3),
        .output_sel (output_sel3),
        .acc_hold   (acc_hold3),
        .busy       (busy3),
        .out_data   (out_data3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive after the rising edge, observe on the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
        start = 1'b0;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ready_phase % 3 == 0);
            default: out_ready = 1'b0;
        endcase
        ready_phase++;
        @(negedge clock);
        if (pend_stall) begin
            check("stall_valid", {31'b0, out_valid}, 1);
            check("stall_data", {24'b0, out_data}, {24'b0, pend_data});
        end
        if (expect_idle) begin
            check("end_busy", {31'b0, busy}, 0);
            check("end_valid", {31'b0, out_valid}, 0);
            expect_idle = 1'b0;
        end
        if (acc_hold) begin
            hold_cycles++;
            sel_cycles[output_sel]++;
            if (output_sel < last_sel) sel_order_bad = 1'b1;
            last_sel = output_sel;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %0h expected no byte", out_data);
            end else begin
                check("frame_byte", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
                pops++;
                if (exp_q.size() == 0) expect_idle = 1'b1;
                if (pops == inject_at) begin
                    start = 1'b1;
                    inject_at = -1;
                end
            end
        end
        pend_stall = out_valid && !out_ready;
        pend_data  = out_data;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        m_lsb = v.lsb;
        m_msb = v.msb;
        m_cnt = v.cnt;
        m_carry = v.carry_src;
        ready_mode = v.ready_mode;
        inject_at = v.inject_at;
        pops = 0;
        hold_cycles = 0;
        foreach (sel_cycles[k]) sel_cycles[k] = 0;
        sel_order_bad = 1'b0;
        last_sel = 3'd0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(v.lsb);
        exp_q.push_back(v.msb);
        exp_q.push_back(v.cnt);
        exp_q.push_back(v.carry_exp);
`ifdef ACC_READOUT_CHKSUM_EN
        exp_q.push_back(v.csum);
`endif
        start = 1'b1;
        tick();
        n = 1;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("hdr_latency", n, 9);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got %0d bytes left expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        check("hold_cycles", hold_cycles, 8);
        for (int k = 0; k < 4; k++) check("sel_hold", sel_cycles[k], 2);
        check("sel_order", {31'b0, sel_order_bad}, 0);
        repeat (4) tick();
        check("no_restart", {31'b0, busy}, 0);
        check("idle_sel", {29'b0, output_sel}, 0);
    endtask

    initial begin
        logic [7:0] exp3[6];
        int n, h3;
        int sel3c[8];
        total = 0;
        bad = 0;
        pops = 0;
        ready_mode = 0;
        ready_phase = 0;
        inject_at = -1;
        hold_cycles = 0;
        sel_order_bad = 1'b0;
        pend_stall = 1'b0;
        expect_idle = 1'b0;
        last_sel = 3'd0;
        pend_data = 8'h00;
        foreach (sel_cycles[k]) sel_cycles[k] = 0;
        m_lsb = 8'h34;
        m_msb = 8'h12;
        m_cnt = 8'h05;
        m_carry = 8'h01;
        reset = 1'b0;
        start = 1'b0;
        start3 = 1'b0;
        out_ready = 1'b0;

        // lsb msb cnt carry_src carry_exp csum ready_mode inject_at
        vecs[0] = '{8'h34, 8'h12, 8'h05, 8'h01, 8'h01, 8'h22, 0, -1};
        vecs[1] = '{8'h34, 8'h12, 8'h05, 8'h01, 8'h01, 8'h22, 1, -1};
        vecs[2] = '{8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h01, 8'hF1, 0, 2};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 1, FrameLen};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 8'h03, 8'h01, 8'hFF, 0, -1};

        #23;
        check("rst_sel", {29'b0, output_sel}, 0);
        check("rst_hold", {31'b0, acc_hold}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_data", {24'b0, out_data}, 0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset while byte 2 of the payload is on the bus
        m_lsb = 8'h11;
        m_msb = 8'h22;
        m_cnt = 8'h33;
        m_carry = 8'h01;
        ready_mode = 0;
        inject_at = -1;
        pops = 0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        start = 1'b1;
        n = 0;
        while (pops < 3 && n < 100) begin
            tick();
            n++;
        end
        ready_mode = 2;
        tick();
        check("abort_byte2", {24'b0, out_data}, 32'h33);
        reset = 1'b0;
        #2;
        check("abort_valid", {31'b0, out_valid}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_hold", {31'b0, acc_hold}, 0);
        exp_q.delete();
        pend_stall = 1'b0;
        expect_idle = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        run_vec(vecs[4]);

        // Long settle instance: each select held four cycles
        m_lsb = 8'h34;
        m_msb = 8'h12;
        m_cnt = 8'h05;
        m_carry = 8'h01;
        ready_mode = 0;
        exp3 = '{8'hA5, 8'h34, 8'h12, 8'h05, 8'h01, 8'h22};
        foreach (sel3c[k]) sel3c[k] = 0;
        h3 = 0;
        n = 0;
        start3 = 1'b1;
        do begin
            tick();
            start3 = 1'b0;
            n++;
            if (acc_hold3) begin
                h3++;
                sel3c[output_sel3]++;
            end
        end while (!out_valid3 && n < 100);
        check("s3_hdr_latency", n, 17);
        check("s3_hold", h3, 16);
        for (int k = 0; k < 4; k++) check("s3_sel_hold", sel3c[k], 4);
        for (int k = 0; k < FrameLen; k++) begin
            check("s3_byte", {24'b0, out_data3}, {24'b0, exp3[k]});
            tick();
        end
        check("s3_end_busy", {31'b0, busy3}, 0);
        check("s3_end_valid", {31'b0, out_valid3}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_readout.md
Name: acc_readout

Overview:
- Downstream readout stage for the adder/accumulator.
- Sequences the accumulator's 3-bit output select, snapshots the four result fields, and ships them as a framed byte stream over a valid/ready handshake toward the host/UART side.
- Asserts a hold request during the snapshot so the sampled fields are mutually consistent.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- SETTLE_CYCLES, 1, cycles waited after changing output_sel before sampling acc_data (1..7).

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to read out and transmit one frame.
- acc_data  input  8  accumulator data_out (combinational mux output).
- output_sel  output  3  select driven to the accumulator mux.
- acc_hold  output  1  high while snapshotting; upstream gates add/load with it.
- busy  output  1  high from accepted start until the last byte handshakes.
- out_data  output  8  frame byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.

Behaviour:
- Select encoding (package constants):
  - SEL_LSB = 0: reg2[7:0].
  - SEL_MSB = 1: reg2[15:8].
  - SEL_CNT = 2: counter value.
  - SEL_CARRY = 3: carry in bit 0, bits 7:1 zero.
  - Codes 4-7 are never driven.
- Reset (async, active-low) outputs: output_sel = 0, acc_hold = 0, busy = 0, out_valid = 0, out_data = 0. Snapshot buffer and field index are cleared; FSM goes to IDLE.
- FSM states:
  - IDLE: start = 1 moves to SNAP. Next cycle: busy = 1, acc_hold = 1, output_sel = SEL_LSB, field index = 0, settle counter = SETTLE_CYCLES.
  - SNAP: the settle counter decrements each cycle. At 0, acc_data is written into buf[index].
    - If index < 3: index increments, output_sel = index + 1, counter reloads.
    - If index = 3: go to HDR; acc_hold drops the same edge; output_sel returns to 0.
    - Snapshot latency with SETTLE_CYCLES = 1 is 4 x (SETTLE_CYCLES + 1) = 8 cycles from start to HDR.
  - HDR: out_valid = 1, out_data = HEADER. On handshake go to PAY with byte index 0.
  - PAY: out_data = buf[i]. On handshake i increments. After i = 3 is accepted, go to CSUM if CHKSUM_EN, else to IDLE with busy = 0 and out_valid = 0 on that edge.
  - CSUM: out_data = XOR of buf[0..3]. On handshake go to IDLE.
- Handshake rules:
  - out_valid never drops and out_data never changes until the handshake.
  - Back-to-back bytes are allowed: with out_ready tied high, one byte per cycle.
- start while busy is ignored, not queued.
- start in the same cycle busy falls is also ignored, because busy is still 1 that cycle.
- out_ready while out_valid = 0 has no effect.
- Carry byte is forced to {7'b0, acc_data[0]}, regardless of the upper bits.
- Reset mid-frame aborts immediately: a partial frame is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro ACC_READOUT_CHKSUM_EN.
- Defined: the frame is 6 bytes: HEADER, LSB, MSB, CNT, CARRY, then XOR of the four payload bytes (header excluded).
- Undefined: the frame is 5 bytes; the CSUM state and its XOR logic are not synthesized.

Decomposition:
- Shared package acc_pkg holds:
  - SEL_* select codes and the SEL_WIDTH = 3 constant.
  - The readout FSM state enum (IDLE, SNAP, HDR, PAY, CSUM).
  - Default frame header constant.
  - Package also used by the accumulator mux.
- One sub-module: acc_snapshot. It holds the select sequencer, settle counter and 4-byte capture buffer, and gives a done pulse plus buffer outputs. The top holds the framing/handshake FSM.

Test Plan:
- Reset, then start, with out_ready = 1 and the accumulator model presenting LSB = 8'h34, MSB = 8'h12, CNT = 8'h05, carry = 1 -> output_sel steps 0,1,2,3 with each code held 2 cycles and acc_hold high for 8 cycles. Stream is A5 34 12 05 01, plus 22 when ACC_READOUT_CHKSUM_EN is defined. busy falls with the last byte.
- Same frame with out_ready toggling 1,0,0,1,... -> each byte held stable while stalled; no byte lost or duplicated.
- Second start pulse while PAY is in progress -> ignored; exactly one frame is emitted.
- Reset driven low during PAY at byte 2 -> out_valid = 0 and busy = 0 without waiting for a clock. The next start yields a complete fresh frame.
- Carry source presents 8'hFF -> carry byte is 8'h01.
- SETTLE_CYCLES = 3 -> each select is held 4 cycles; snapshot takes 16 cycles before the header appears.
